// File: rtl/exa_crosb_out_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exa_crosb_out_arbiter                                                    |
// | Per-output packet arbiter: two-class round-robin, grant held per packet. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module exa_crosb_out_arbiter #(
  parameter int INPUT_NUM = 16,
  parameter int SEL_WIDTH = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INPUT_NUM-1:0] REQ_i,
  input  logic [INPUT_NUM-1:0] PRIO_i,
  input  logic                 OUT_VALID_i,
  input  logic                 OUT_LAST_i,
  input  logic                 OUT_READY_i,
  output logic [SEL_WIDTH-1:0] SEL_o,
  output logic [INPUT_NUM-1:0] GRANT_o,
  output logic                 BUSY_o,
  output logic                 PRIO_GRANT_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [INPUT_NUM-1:0] r_grant, w_grant_nxt;
  logic [SEL_WIDTH-1:0] r_sel, w_sel_nxt;
  logic                 r_prio, w_prio_nxt;
  logic [SEL_WIDTH-1:0] r_hi_ptr, w_hi_ptr_nxt;
  logic [SEL_WIDTH-1:0] r_lo_ptr, w_lo_ptr_nxt;

  logic [INPUT_NUM-1:0] w_hi_req;
  logic                 w_use_hi;
  logic [INPUT_NUM-1:0] w_cand;
  logic [SEL_WIDTH-1:0] w_base;
  logic [SEL_WIDTH:0]   w_sum;
  logic                 w_found;
  logic [SEL_WIDTH-1:0] w_win;
  logic [SEL_WIDTH-1:0] w_win_inc;
  logic [INPUT_NUM-1:0] w_win_oh;
  logic                 w_last_hs;

  // High class wins outright; each class scans from its own pointer, wrapping.
  always_comb begin
    w_hi_req = REQ_i & PRIO_i;
    w_use_hi = |w_hi_req;
    w_cand   = w_use_hi ? w_hi_req : REQ_i;
    w_base   = w_use_hi ? r_hi_ptr : r_lo_ptr;
    w_sum    = '0;
    w_found  = 1'b0;
    w_win    = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      w_sum = {1'b0, w_base} + (SEL_WIDTH+1)'(i);
      if (w_sum >= (SEL_WIDTH+1)'(INPUT_NUM)) begin
        w_sum = w_sum - (SEL_WIDTH+1)'(INPUT_NUM);
      end
      if (!w_found && w_cand[w_sum[SEL_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[SEL_WIDTH-1:0];
      end
    end
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
    w_win_inc = (w_win == SEL_WIDTH'(INPUT_NUM-1)) ? '0 : w_win + 1'b1;
  end

  assign w_last_hs = OUT_VALID_i & OUT_READY_i & OUT_LAST_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_sel_nxt    = r_sel;
    w_prio_nxt   = r_prio;
    w_hi_ptr_nxt = r_hi_ptr;
    w_lo_ptr_nxt = r_lo_ptr;
    case (r_state)
      S_IDLE: begin
        if (|REQ_i) begin
          w_state_nxt = S_BUSY;
          w_grant_nxt = w_win_oh;
          w_sel_nxt   = w_win;
          w_prio_nxt  = w_use_hi;
          if (w_use_hi) begin
            w_hi_ptr_nxt = w_win_inc;
          end else begin
            w_lo_ptr_nxt = w_win_inc;
          end
        end
      end
      S_BUSY: begin
        // SEL is left on the last winner after release.
        if (w_last_hs) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_prio_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_prio_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_sel    <= '0;
      r_prio   <= 1'b0;
      r_hi_ptr <= '0;
      r_lo_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_sel    <= w_sel_nxt;
      r_prio   <= w_prio_nxt;
      r_hi_ptr <= w_hi_ptr_nxt;
      r_lo_ptr <= w_lo_ptr_nxt;
    end
  end

  assign SEL_o        = r_sel;
  assign GRANT_o      = r_grant;
  assign BUSY_o       = (r_state == S_BUSY);
  assign PRIO_GRANT_o = r_prio;

endmodule
`default_nettype wire
